// File: rtl/hdmi_align_pkg.sv
// rtl/hdmi_align_pkg.sv - shared mode codes, FSM states and colour-bar table for the HDMI aligner
package hdmi_align_pkg;

    localparam logic [1:0] MODE_BYPASS = 2'b00;
    localparam logic [1:0] MODE_PROC   = 2'b01;
    localparam logic [1:0] MODE_SPLIT  = 2'b10;
    localparam logic [1:0] MODE_TEST   = 2'b11;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } align_state_e;

    // {R,G,B} on/off per bar, left to right
    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        case (idx)
            3'd0:    return 3'b111;
            3'd1:    return 3'b110;
            3'd2:    return 3'b011;
            3'd3:    return 3'b010;
            3'd4:    return 3'b101;
            3'd5:    return 3'b100;
            3'd6:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/hdmi_delay_line.sv
// rtl/hdmi_delay_line.sv - fixed-depth shift register with synchronous clear
module hdmi_delay_line #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         clear,
    input  logic [W-1:0] data,
    output logic [W-1:0] delayed
);

    logic [W-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= data;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign delayed = stage[DEPTH-1];

endmodule

// File: rtl/hdmi_stream_aligner.sv
// rtl/hdmi_stream_aligner.sv - latency-matched pixel aligner with mode switching and geometry; option ALIGN_TEST_PATTERN_EN
module hdmi_stream_aligner
    import hdmi_align_pkg::*;
#(
    parameter int PIX_W   = 24,
    parameter int LATENCY = 16,
    parameter int CNT_W   = 12,
    parameter int VS_POL  = 1
) (
    input  logic             pclk,
    input  logic             rstin,
    input  logic             in_de,
    input  logic             in_hsync,
    input  logic             in_vsync,
    input  logic [PIX_W-1:0] in_pixel,
    output logic [PIX_W-1:0] to_proc_pixel,
    output logic             to_proc_valid,
    input  logic [PIX_W-1:0] from_proc_pixel,
    input  logic [1:0]       mode_req,
    output logic             out_de,
    output logic             out_hsync,
    output logic             out_vsync,
    output logic [PIX_W-1:0] out_pixel,
    output logic [1:0]       mode_active,
    output logic [CNT_W-1:0] h_active,
    output logic [CNT_W-1:0] v_active,
    output logic             geom_valid,
    output logic             fill_done
);

    localparam int   FILL_W  = $clog2(LATENCY + 1);
    localparam logic VS_IDLE = (VS_POL == 0);

    function automatic logic [CNT_W-1:0] inc_sat(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    align_state_e      state;
    logic [FILL_W-1:0] fill_cnt;
    logic              dly_de, dly_hs, dly_vs;
    logic [PIX_W-1:0]  dly_pixel;
    logic              dly_vs_act, dly_vs_q, out_vs_rise;
    logic [CNT_W-1:0]  col;
    logic [PIX_W-1:0]  sel_pixel;

    logic              vs_act, in_vs_q, vs_rise, de_fall;
    logic [CNT_W-1:0]  hcnt, vcnt, line_w, cur_line, cur_v;
    logic              geom_primed;

    hdmi_delay_line #(.W(3), .DEPTH(LATENCY)) u_timing_dly (
        .clk     (pclk),
        .clear   (rstin),
        .data    ({in_de, in_hsync, in_vsync}),
        .delayed ({dly_de, dly_hs, dly_vs})
    );

    hdmi_delay_line #(.W(PIX_W), .DEPTH(LATENCY)) u_pixel_dly (
        .clk     (pclk),
        .clear   (rstin),
        .data    (in_pixel),
        .delayed (dly_pixel)
    );

    always_ff @(posedge pclk) begin
        if (rstin) begin
            to_proc_pixel <= '0;
            to_proc_valid <= 1'b0;
        end else begin
            to_proc_pixel <= in_pixel;
            to_proc_valid <= in_de;
        end
    end

    assign dly_vs_act  = (VS_POL != 0) ? dly_vs : ~dly_vs;
    assign out_vs_rise = dly_vs_act & ~dly_vs_q;
    assign fill_done   = (state != ST_FILL);

    // Mode changes only land on an output-side frame boundary
    always_ff @(posedge pclk) begin
        if (rstin) begin
            state       <= ST_FILL;
            fill_cnt    <= '0;
            mode_active <= MODE_BYPASS;
            dly_vs_q    <= 1'b0;
        end else begin
            dly_vs_q <= dly_vs_act;
            case (state)
                ST_FILL: begin
                    if (fill_cnt == FILL_W'(LATENCY - 1)) begin
                        fill_cnt <= FILL_W'(LATENCY);
                        state    <= ST_RUN;
                    end else begin
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (mode_req != mode_active) state <= ST_PEND;
                end
                ST_PEND: begin
                    if (out_vs_rise) begin
                        mode_active <= mode_req;
                        state       <= ST_RUN;
                    end else if (mode_req == mode_active) begin
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_FILL;
            endcase
        end
    end

    // col is the column of the pixel currently leaving the delay line
    always_ff @(posedge pclk) begin
        if (rstin)       col <= '0;
        else if (dly_de) col <= inc_sat(col);
        else             col <= '0;
    end

`ifdef ALIGN_TEST_PATTERN_EN
    logic [CNT_W+2:0] bar_edge;
    logic [2:0]       bar_idx;
    logic [2:0]       bar_on;
    logic [PIX_W-1:0] bar_pixel;

    // Bar index = how many multiples of h_active/8 the column has passed, capped at 7
    always_comb begin
        bar_idx  = 3'd0;
        bar_edge = '0;
        for (int i = 1; i < 8; i++) begin
            bar_edge = bar_edge + {3'b000, h_active >> 3};
            if ({3'b000, col} >= bar_edge) bar_idx = 3'(i);
        end
    end

    assign bar_on    = bar_rgb(bar_idx);
    assign bar_pixel = {{(PIX_W/3){bar_on[2]}}, {(PIX_W/3){bar_on[1]}}, {(PIX_W/3){bar_on[0]}}};
`endif

    always_comb begin
        sel_pixel = dly_pixel;
        case (mode_active)
            MODE_PROC:  sel_pixel = from_proc_pixel;
            MODE_SPLIT: if (geom_valid && col >= (h_active >> 1)) sel_pixel = from_proc_pixel;
`ifdef ALIGN_TEST_PATTERN_EN
            MODE_TEST:  sel_pixel = bar_pixel;
`else
            MODE_TEST:  sel_pixel = dly_pixel;
`endif
            default:    sel_pixel = dly_pixel;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rstin || state == ST_FILL) begin
            out_de    <= 1'b0;
            out_hsync <= 1'b0;
            out_vsync <= VS_IDLE;
            out_pixel <= '0;
        end else begin
            out_de    <= dly_de;
            out_hsync <= dly_hs;
            out_vsync <= dly_vs;
            out_pixel <= dly_de ? sel_pixel : '0;
        end
    end

    assign vs_act   = (VS_POL != 0) ? in_vsync : ~in_vsync;
    assign vs_rise  = vs_act & ~in_vs_q;
    assign de_fall  = to_proc_valid & ~in_de;
    assign cur_line = de_fall ? hcnt : line_w;
    assign cur_v    = de_fall ? inc_sat(vcnt) : vcnt;

    // The first latch after reset only primes the comparison
    always_ff @(posedge pclk) begin
        if (rstin) begin
            in_vs_q     <= 1'b0;
            hcnt        <= '0;
            vcnt        <= '0;
            line_w      <= '0;
            h_active    <= '0;
            v_active    <= '0;
            geom_valid  <= 1'b0;
            geom_primed <= 1'b0;
        end else begin
            in_vs_q <= vs_act;
            hcnt    <= in_de ? inc_sat(hcnt) : '0;
            if (de_fall) line_w <= hcnt;
            if (vs_rise) begin
                h_active    <= cur_line;
                v_active    <= cur_v;
                geom_valid  <= geom_primed && (cur_line == h_active) && (cur_v == v_active);
                geom_primed <= 1'b1;
                vcnt        <= '0;
            end else begin
                vcnt <= cur_v;
            end
        end
    end

endmodule
